stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 147 ++++++++++++++
 tb/tb_stage_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Game stage sequencer: title -> levels 1..NUM_LEVELS -> win, with game-over and clear-hold timing.
// Optional level pause is built when the macro STAGE_PAUSE_EN is defined.
module stage_sequencer #(
    parameter int NUM_LEVELS      = 4,
    parameter int KILLS_PER_LEVEL = 2,
    parameter int KILL_W          = 4,
    parameter int HOLD_CYCLES     = 100,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gameover,
    input  logic [KILL_W-1:0] kills,
    input  logic              space,
    input  logic              pause_key,
    output logic [3:0]        stage,
    output logic              changing_stage,
    output logic              paused,
    output logic [CNT_W-1:0]  hold_count
);

    localparam int               TH_W       = KILL_W + 4;
    localparam logic [3:0]       STG_TITLE  = 4'h0;
    localparam logic [3:0]       STG_WIN    = 4'hE;
    localparam logic [3:0]       STG_OVER   = 4'hF;
    localparam logic [3:0]       LAST_LEVEL = 4'(NUM_LEVELS);
    localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        PH_TITLE,
        PH_LEVEL,
        PH_WIN,
        PH_OVER
    } phase_t;

    phase_t           phase_q, phase_d;
    logic [3:0]       stage_q, stage_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             changing_q, changing_d;
    logic             space_q;
    logic             space_edge;
    logic             level_paused;
    logic [TH_W-1:0]  threshold;
    logic             cleared;
    logic             stage_change;

    assign space_edge = space & ~space_q;
    assign threshold  = TH_W'(stage_q) * TH_W'(KILLS_PER_LEVEL);
    assign cleared    = TH_W'(kills) >= threshold;

    always_comb begin
        phase_d = phase_q;
        stage_d = stage_q;
        hold_d  = HOLD_INIT;
        unique case (phase_q)
            PH_TITLE: begin
                if (space_edge) begin
                    phase_d = PH_LEVEL;
                    stage_d = 4'h1;
                end
            end
            PH_LEVEL: begin
                if (gameover) begin
                    phase_d = PH_OVER;
                    stage_d = STG_OVER;
                end else if (hold_q == '0 && !level_paused) begin
                    if (stage_q == LAST_LEVEL) begin
                        phase_d = PH_WIN;
                        stage_d = STG_WIN;
                    end else begin
                        stage_d = stage_q + 4'h1;
                    end
                end
                if (level_paused)       hold_d = hold_q;
                else if (!cleared)      hold_d = HOLD_INIT;
                else if (hold_q == '0)  hold_d = HOLD_INIT;
                else                    hold_d = hold_q - CNT_W'(1);
            end
            PH_WIN, PH_OVER: begin
                if (space_edge) begin
                    phase_d = PH_TITLE;
                    stage_d = STG_TITLE;
                end
            end
            default: begin
                phase_d = PH_TITLE;
                stage_d = STG_TITLE;
            end
        endcase
        stage_change = (stage_d != stage_q);
        // Every new stage starts with a fresh hold window.
        if (stage_change) hold_d = HOLD_INIT;
        changing_d = stage_change;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q    <= PH_TITLE;
            stage_q    <= STG_TITLE;
            hold_q     <= HOLD_INIT;
            changing_q <= 1'b0;
            space_q    <= 1'b1;
        end else begin
            phase_q    <= phase_d;
            stage_q    <= stage_d;
            hold_q     <= hold_d;
            changing_q <= changing_d;
            space_q    <= space;
        end
    end

`ifdef STAGE_PAUSE_EN
    logic pause_q;
    logic pause_edge;
    logic paused_q, paused_d;

    assign pause_edge = pause_key & ~pause_q;

    always_comb begin
        paused_d = paused_q;
        if (stage_change)                          paused_d = 1'b0;
        else if (phase_q == PH_LEVEL && pause_edge) paused_d = ~paused_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pause_q  <= 1'b1;
            paused_q <= 1'b0;
        end else begin
            pause_q  <= pause_key;
            paused_q <= paused_d;
        end
    end

    assign level_paused = paused_q;
`else
    logic unused_pause_key;
    assign unused_pause_key = pause_key;
    assign level_paused     = 1'b0;
`endif

    assign stage          = stage_q;
    assign changing_stage = changing_q;
    assign paused         = level_paused;
    assign hold_count     = hold_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus random stimulus against a cycle model.
// Pause scenarios follow STAGE_PAUSE_EN, matching the build of the design.
module tb_stage_sequencer;

    localparam int N = 4;
    localparam int K = 2;
    localparam int H = 100;
`ifdef STAGE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, gameover, space, pause_key;
    logic [3:0] kills;
    logic [3:0] stage;
    logic       changing_stage, paused;
    logic [7:0] hold_count;

    int checks   = 0;
    int failures = 0;

    int m_stage, m_hold;
    bit m_chg, m_paused, m_sp, m_pp;

    stage_sequencer #(
        .NUM_LEVELS(N),
        .KILLS_PER_LEVEL(K),
        .KILL_W(4),
        .HOLD_CYCLES(H),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .gameover(gameover),
        .kills(kills),
        .space(space),
        .pause_key(pause_key),
        .stage(stage),
        .changing_stage(changing_stage),
        .paused(paused),
        .hold_count(hold_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: one clock edge of the game rules applied to integer state.
    task automatic model_step();
        bit se, pe, clr;
        int ns, nh;
        bit np;
        if (!rst_n) begin
            m_stage = 0; m_hold = H; m_chg = 0; m_paused = 0; m_sp = 1; m_pp = 1;
            return;
        end
        se = space && !m_sp;
        pe = pause_key && !m_pp;
        ns = m_stage; nh = H; np = m_paused;
        if (m_stage == 0) begin
            if (se) ns = 1;
        end else if (m_stage <= N) begin
            clr = (int'(kills) >= m_stage * K);
            if (gameover) ns = 15;
            else if (m_hold == 0 && !m_paused) ns = (m_stage == N) ? 14 : m_stage + 1;
            if (m_paused)        nh = m_hold;
            else if (!clr)       nh = H;
            else if (m_hold == 0) nh = H;
            else                 nh = m_hold - 1;
            if (PAUSE_EN && pe) np = !m_paused;
        end else begin
            if (se) ns = 0;
        end
        if (ns != m_stage) begin
            nh = H;
            np = 0;
        end
        m_chg = (ns != m_stage);
        m_stage = ns; m_hold = nh; m_paused = np;
        m_sp = space; m_pp = pause_key;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("stage", int'(stage), m_stage);
        chk("changing_stage", int'(changing_stage), int'(m_chg));
        chk("paused", int'(paused), int'(m_paused));
        chk("hold_count", int'(hold_count), m_hold);
    endtask

    task automatic wait_stage(input int target, input int bound, output int n);
        n = 0;
        while (int'(stage) != target && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_hold(input int target, input int bound);
        int n;
        n = 0;
        while (int'(hold_count) != target && n < bound) begin
            tick();
            n++;
        end
        chk("hold_reached", int'(hold_count), target);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; gameover = 1'b0; space = 1'b1; pause_key = 1'b0; kills = 4'd0;

        // Reset with space held; release must not start a level.
        repeat (3) tick();
        chk("reset_stage", int'(stage), 0);
        chk("reset_hold", int'(hold_count), H);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("space_held_title", int'(stage), 0);

        // Title -> level 1 with a one-cycle changing_stage pulse.
        space = 1'b0; tick();
        space = 1'b1; tick();
        chk("enter_l1", int'(stage), 1);
        chk("enter_l1_pulse", int'(changing_stage), 1);
        space = 1'b0; tick();
        chk("pulse_one_cycle", int'(changing_stage), 0);

        // Level 1: interrupted hold reloads, then uninterrupted hold advances after 101 cycles.
        kills = 4'd2;
        repeat (50) tick();
        chk("hold_mid", int'(hold_count), H - 50);
        kills = 4'd1; tick();
        chk("hold_reload", int'(hold_count), H);
        repeat (20) tick();
        chk("no_advance", int'(stage), 1);
        kills = 4'd2;
        wait_stage(2, 300, n);
        chk("advance_latency_l1", n, H + 1);

        // Level 2: gameover beats hold_count==0.
        kills = 4'd4;
        wait_hold(0, 200);
        gameover = 1'b1; tick();
        chk("gameover_wins", int'(stage), 15);
        gameover = 1'b0;
        space = 1'b1; tick();
        chk("over_to_title", int'(stage), 0);
        space = 1'b0; tick();

        // Full run through the last level to the win stage.
        space = 1'b1; tick();
        space = 1'b0;
        kills = 4'd15;
        for (int lv = 2; lv <= N; lv++) begin
            wait_stage(lv, 300, n);
            chk("advance_latency", n, H + 1);
        end
        wait_stage(14, 300, n);
        chk("win_latency", n, H + 1);
        chk("win_stage", int'(stage), 14);
        chk("win_hold", int'(hold_count), H);
        tick();
        space = 1'b1; tick();
        chk("win_to_title", int'(stage), 0);
        space = 1'b0; tick();

        // Reset in the middle of a hold aborts silently to title.
        space = 1'b1; tick();
        space = 1'b0; kills = 4'd2;
        repeat (30) tick();
        rst_n = 1'b0; tick();
        chk("midhold_rst_stage", int'(stage), 0);
        chk("midhold_rst_hold", int'(hold_count), H);
        chk("midhold_rst_pulse", int'(changing_stage), 0);
        rst_n = 1'b1; tick();

        // Pause behaviour in level 1.
        kills = 4'd0;
        space = 1'b1; tick();
        space = 1'b0; tick();
`ifdef STAGE_PAUSE_EN
        kills = 4'd2;
        wait_hold(61, 200);
        pause_key = 1'b1; tick();
        chk("paused_set", int'(paused), 1);
        pause_key = 1'b0;
        repeat (30) tick();
        chk("frozen_hold", int'(hold_count), 60);
        pause_key = 1'b1; tick();
        chk("paused_clear", int'(paused), 0);
        pause_key = 1'b0; tick();
        chk("resumed_hold", int'(hold_count), 59);
`else
        repeat (3) begin
            pause_key = 1'b1; tick();
            pause_key = 1'b0; tick();
        end
        chk("paused_const", int'(paused), 0);
`endif
        gameover = 1'b1; tick();
        gameover = 1'b0;
        space = 1'b1; tick();
        space = 1'b0; tick();

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) space = ~space;
            if ($urandom_range(0, 99) < 3) pause_key = ~pause_key;
            if ($urandom_range(0, 49) == 0) kills = 4'($urandom_range(0, 15));
            gameover = ($urandom_range(0, 299) == 0);
            rst_n    = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
